// File: rtl/counter_mod_updn_pkg.sv
// Shared types for the modulo-N up/down counter: operation enum and the
// priority decode from the raw control inputs.
package counter_pkg;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_CLR,
        OP_LOAD,
        OP_INC,
        OP_DEC
    } counter_op_e;

    // Clear beats load beats counting; up and down together cancel to a hold.
    function automatic counter_op_e decode_op(
        input logic clr,
        input logic parallel,
        input logic increase,
        input logic decrease
    );
        counter_op_e op;
        if (clr)
            op = OP_CLR;
        else if (parallel)
            op = OP_LOAD;
        else if (increase && !decrease)
            op = OP_INC;
        else if (decrease && !increase)
            op = OP_DEC;
        else
            op = OP_HOLD;
        return op;
    endfunction

endpackage

// File: rtl/counter_mod_updn_if.sv
// Control and status bundle of the modulo-N counter; the master drives the
// requests, the slave (the counter) returns the registered count and strobes.
interface counter_mod_updn_if #(
    parameter int WIDTH = 8
);
    logic             CLR;
    logic             parallel;
    logic [WIDTH-1:0] load;
    logic             increase;
    logic             decrease;
    logic [WIDTH-1:0] Q_OUT;
    logic             TC_UP;
    logic             TC_DN;
    logic             ZERO;
    logic             AT_MAX;

    modport master (
        output CLR, parallel, load, increase, decrease,
        input  Q_OUT, TC_UP, TC_DN, ZERO, AT_MAX
    );

    modport slave (
        input  CLR, parallel, load, increase, decrease,
        output Q_OUT, TC_UP, TC_DN, ZERO, AT_MAX
    );
endinterface

// File: rtl/counter_mod_updn_next_val.sv
// Combinational next-count logic: load clamp, wrap-around and, when
// COUNTER_MOD_UPDN_SAT_EN is defined, saturation at the bounds.
module counter_next_val
    import counter_pkg::*;
#(
    parameter int              WIDTH = 8,
    parameter longint unsigned MOD   = 64'd1 << WIDTH
) (
    input  counter_op_e      op,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] load,
    output logic [WIDTH-1:0] next_q,
    output logic             wrap_up,
    output logic             wrap_dn
);
    // One spare bit so a full-range modulus (MOD = 2**WIDTH) still compares cleanly.
    localparam logic [WIDTH:0] MAX_VAL = (WIDTH+1)'(MOD - 64'd1);

    logic [WIDTH:0] q_ext;
    logic [WIDTH:0] load_ext;

    always_comb begin
        q_ext    = {1'b0, q};
        load_ext = {1'b0, load};
        next_q   = q;
        wrap_up  = 1'b0;
        wrap_dn  = 1'b0;
        case (op)
            OP_CLR:  next_q = '0;
            OP_LOAD: next_q = (load_ext > MAX_VAL) ? MAX_VAL[WIDTH-1:0] : load;
            OP_INC: begin
                if (q_ext == MAX_VAL) begin
                    wrap_up = 1'b1;
`ifdef COUNTER_MOD_UPDN_SAT_EN
                    next_q  = q;
`else
                    next_q  = '0;
`endif
                end else begin
                    next_q = WIDTH'(q_ext + 1'b1);
                end
            end
            OP_DEC: begin
                if (q_ext == '0) begin
                    wrap_dn = 1'b1;
`ifdef COUNTER_MOD_UPDN_SAT_EN
                    next_q  = q;
`else
                    next_q  = MAX_VAL[WIDTH-1:0];
`endif
                end else begin
                    next_q = WIDTH'(q_ext - 1'b1);
                end
            end
            default: next_q = q;
        endcase
    end
endmodule

// File: rtl/counter_mod_updn.sv
// Modulo-N up/down counter with load, clear and registered terminal-count
// strobes; all outputs are flops. Saturating mode: COUNTER_MOD_UPDN_SAT_EN.
module counter_mod_updn
    import counter_pkg::*;
#(
    parameter int              WIDTH = 8,
    parameter longint unsigned MOD   = 64'd1 << WIDTH
) (
    input  logic              CLK,
    input  logic              CLR_N,
    counter_mod_updn_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MOD - 64'd1);

    counter_op_e      op;
    logic [WIDTH-1:0] next_q;
    logic             wrap_up;
    logic             wrap_dn;

    assign op = decode_op(bus.CLR, bus.parallel, bus.increase, bus.decrease);

    counter_next_val #(
        .WIDTH (WIDTH),
        .MOD   (MOD)
    ) u_next_val (
        .op      (op),
        .q       (bus.Q_OUT),
        .load    (bus.load),
        .next_q  (next_q),
        .wrap_up (wrap_up),
        .wrap_dn (wrap_dn)
    );

    // Flags are derived from next_q so they line up with the count they describe.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            bus.Q_OUT  <= '0;
            bus.TC_UP  <= 1'b0;
            bus.TC_DN  <= 1'b0;
            bus.ZERO   <= 1'b1;
            bus.AT_MAX <= 1'b0;
        end else begin
            bus.Q_OUT  <= next_q;
            bus.TC_UP  <= wrap_up;
            bus.TC_DN  <= wrap_dn;
            bus.ZERO   <= (next_q == '0);
            bus.AT_MAX <= (next_q == MAX_Q);
        end
    end
endmodule

// File: doc/counter_mod_updn.md
# counter_mod_updn

Parametrised modulo-N up/down counter with parallel load, synchronous clear and registered terminal-count strobes. It is the general-purpose successor to the fixed 4-bit up/down/load counter. Arbitrary width and modulus make it usable for timers, address sequencers and cascaded counter chains, where the carry/borrow strobes feed the next stage.

## Interface
- `WIDTH`, default 8: counter width in bits; legal range 1..32.
- `MOD`, default 2**WIDTH: count modulus; the count range is 0..MOD-1; legal range 2..2**WIDTH.
- `CLK`  in  1  clock; all state changes on the rising edge.
- `CLR_N`  in  1  asynchronous, active-low reset.
- `CLR`  in  1  synchronous clear, active-high.
- `parallel`  in  1  synchronous load request.
- `load`  in  WIDTH  parallel load value.
- `increase`  in  1  count-up request.
- `decrease`  in  1  count-down request.
- `Q_OUT`  out  WIDTH  current count, registered.
- `TC_UP`  out  1  one-cycle strobe: the count wrapped or saturated at MOD-1 on an increment.
- `TC_DN`  out  1  one-cycle strobe: the count wrapped or saturated at 0 on a decrement.
- `ZERO`  out  1  registered; high when Q_OUT == 0.
- `AT_MAX`  out  1  registered; high when Q_OUT == MOD-1.

## Operation
- One clock. Reset is asynchronous and active-low. Clock and reset ports are named `CLK` and `CLR_N`.
- Reset values: Q_OUT=0, TC_UP=0, TC_DN=0, ZERO=1, AT_MAX=0.
- Operation priority each cycle, highest first:
  - CLR: Q_OUT←0.
  - parallel: Q_OUT←load.
  - increase XOR decrease: count by one.
  - Otherwise hold.
- increase and decrease asserted together with no CLR or parallel: hold. No strobe is raised.
- Increment from Q_OUT < MOD-1 gives Q_OUT+1.
- Increment from MOD-1: wrap to 0 and assert TC_UP for the following cycle (saturate mode: see Configuration).
- Decrement from Q_OUT > 0 gives Q_OUT-1.
- Decrement from 0: wrap to MOD-1 and assert TC_DN for the following cycle.
- Load value ≥ MOD is clamped to MOD-1. Load and clear never raise TC_UP or TC_DN.
- ZERO and AT_MAX are computed from the next-state value and registered, so they are coincident with Q_OUT.
- Arithmetic is done at WIDTH+1 bits internally. Q_OUT never holds a value ≥ MOD.

## Timing
- Latency: every request takes effect on Q_OUT one CLK edge after it is sampled.
- TC_UP and TC_DN are registered. Each is high for exactly the one cycle in which Q_OUT shows the post-wrap value, then deasserts unless re-triggered.
- Back-to-back increments at MOD-1: a strobe occurs every MOD cycles, with no gap cycles.
- CLR_N assertion mid-count: all outputs take their reset values immediately, without waiting for CLK.
- CLR_N deassertion: must be synchronised externally. The first operation is sampled on the first rising edge after deassertion.
- No combinational path from any input to any output.

## Configuration
- Macro: `COUNTER_MOD_UPDN_SAT_EN`.
- Defined: saturating mode.
  - Increment at MOD-1 holds at MOD-1 and asserts TC_UP for one cycle.
  - Decrement at 0 holds at 0 and asserts TC_DN for one cycle.
  - Further requests at the bound re-assert the strobe each cycle.
- Undefined (default): wrap-around behaviour as described under Operation.

## Structure
- Shared package `counter_pkg` holds:
  - Op enum `counter_op_e`: OP_HOLD, OP_CLR, OP_LOAD, OP_INC, OP_DEC.
  - Priority-decode function returning `counter_op_e` from CLR, parallel, increase, decrease.
- One sub-module, `counter_next_val`: combinational. It takes op, Q_OUT and load, and returns the next count plus the wrap-up and wrap-down flags. It contains the clamp, wrap and saturate logic. The top level holds only the registers.

## Test plan
- WIDTH=4, MOD=10. Reset, then 12 cycles of increase -> Q_OUT goes 1..9, 0, 1, 2. TC_UP is high only in the cycle Q_OUT=0. AT_MAX is high only when Q_OUT=9.
- WIDTH=4, MOD=10. Hold at 0, then one decrease -> Q_OUT=9, TC_DN pulses once, ZERO falls.
- Each op applied from Q_OUT=5:
  - CLR, parallel (load=3) and increase all asserted -> Q_OUT=0.
  - parallel (load=3) and decrease asserted -> Q_OUT=3.
  - increase and decrease asserted -> Q_OUT=5, with no strobe.
- parallel with load=14, MOD=10 -> Q_OUT=9, AT_MAX=1, TC_UP=0.
- CLR_N pulsed low between edges while Q_OUT=7 -> Q_OUT=0 and ZERO=1 before the next CLK edge.
- With `COUNTER_MOD_UPDN_SAT_EN`, MOD=10, Q_OUT=9, three increases -> Q_OUT stays 9 and TC_UP is high for three cycles.
